// File: rtl/cpu_types_pkg.sv
// Shared types for the memory access controller: the data word and its FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } mem_state_t;

  localparam word_t SC_PASS = 32'd1;
  localparam word_t SC_FAIL = 32'd0;

endpackage

// File: rtl/mem_access_ctrl_link_register.sv
// Load-linked reservation: one valid bit plus the linked address.
module link_register
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set,
  input  word_t set_addr,
  input  logic  clear,
  input  word_t clear_addr,
  input  word_t match_addr,
  output logic  match
);

  logic  valid;
  word_t link_addr;

  // A store only breaks the reservation when it hits the linked address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid     <= 1'b0;
      link_addr <= '0;
    end else if (set) begin
      valid     <= 1'b1;
      link_addr <= set_addr;
    end else if (clear && valid && (link_addr == clear_addr)) begin
      valid <= 1'b0;
    end
  end

  assign match = valid && (link_addr == match_addr);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data cache access controller with stall, done pulse and watchdog.
// Define LLSC_EN to build load-linked / store-conditional support.
module mem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT = 255
)
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dREN_in,
  input  logic  dWEN_in,
  input  logic  ll_in,
  input  logic  sc_in,
  input  word_t addr_in,
  input  word_t store_in,
  input  logic  dhit,
  input  word_t dmemload,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output word_t load_data,
  output logic  mem_stall,
  output logic  mem_done,
  output logic  timeout_err
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  mem_state_t    state;
  word_t         lat_addr;
  word_t         lat_data;
  logic          op_write;
  logic          op_sc;
  logic          op_ll;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_next;
  logic          req;
  logic          in_access;
  logic          sc_fail;

  assign req       = dREN_in | dWEN_in;
  assign in_access = (state == ACCESS);
  assign wait_next = wait_cnt + 1'b1;

`ifdef LLSC_EN
  logic link_match;

  link_register u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (in_access && dhit && !op_write && op_ll),
    .set_addr   (lat_addr),
    .clear      (in_access && dhit && op_write),
    .clear_addr (lat_addr),
    .match_addr (addr_in),
    .match      (link_match)
  );

  // A failed SC never reaches the cache; it retires straight through HOLD.
  assign sc_fail = (state == IDLE) && dWEN_in && sc_in && !link_match;
`else
  logic unused_ll;
  assign unused_ll = op_ll;
  assign sc_fail   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      lat_addr    <= '0;
      lat_data    <= '0;
      op_write    <= 1'b0;
      op_sc       <= 1'b0;
      op_ll       <= 1'b0;
      wait_cnt    <= '0;
      load_data   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr <= addr_in;
            lat_data <= store_in;
            op_write <= dWEN_in;
            op_sc    <= dWEN_in & sc_in;
            op_ll    <= ~dWEN_in & ll_in;
            wait_cnt <= '0;
            if (sc_fail) begin
              load_data <= SC_FAIL;
              state     <= HOLD;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dhit) begin
            if (!op_write) begin
              load_data <= dmemload;
            end else if (op_sc) begin
              load_data <= SC_PASS;
            end
            state <= HOLD;
          end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_next;
            if (wait_next == WAIT_LIMIT) begin
              timeout_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall covers the accepting IDLE cycle so the pipeline cannot slip past the access.
  assign mem_stall = nRST && (in_access || ((state == IDLE) && req));
  assign mem_done  = (state == HOLD);
  assign dmemREN   = in_access && !op_write;
  assign dmemWEN   = in_access && op_write;
  assign dmemaddr  = lat_addr;
  assign dmemstore = lat_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (MAX_WAIT = 4); honours LLSC_EN.
module tb_mem_access_ctrl;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  dREN_in, dWEN_in, ll_in, sc_in, dhit;
  word_t addr_in, store_in, dmemload;
  logic  dmemREN, dmemWEN, mem_stall, mem_done, timeout_err;
  word_t dmemaddr, dmemstore, load_data;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(.MAX_WAIT(4)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .dREN_in     (dREN_in),
    .dWEN_in     (dWEN_in),
    .ll_in       (ll_in),
    .sc_in       (sc_in),
    .addr_in     (addr_in),
    .store_in    (store_in),
    .dhit        (dhit),
    .dmemload    (dmemload),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .load_data   (load_data),
    .mem_stall   (mem_stall),
    .mem_done    (mem_done),
    .timeout_err (timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // Issues one request, delays dhit by 'waits' ACCESS cycles, ends sampled in HOLD.
  task automatic do_access(input logic rd, input logic wr, input logic ll, input logic sc,
                           input word_t addr, input word_t data, input word_t rdata,
                           input int waits, output int ren_cnt, output int wen_cnt,
                           output int stall_cnt);
    ren_cnt = 0; wen_cnt = 0; stall_cnt = 0;
    tick();
    dREN_in = rd; dWEN_in = wr; ll_in = ll; sc_in = sc; addr_in = addr; store_in = data;
    sample();
    ren_cnt += int'(dmemREN); wen_cnt += int'(dmemWEN); stall_cnt += int'(mem_stall);
    for (int i = 0; i <= waits; i++) begin
      tick();
      if (i == waits) begin
        dhit = 1'b1; dmemload = rdata;
      end
      sample();
      ren_cnt += int'(dmemREN); wen_cnt += int'(dmemWEN); stall_cnt += int'(mem_stall);
    end
    tick();
    dhit = 1'b0; dmemload = '0;
    sample();
    ren_cnt += int'(dmemREN); wen_cnt += int'(dmemWEN); stall_cnt += int'(mem_stall);
  endtask

  task automatic finish_access();
    tick();
    dREN_in = 1'b0; dWEN_in = 1'b0; ll_in = 1'b0; sc_in = 1'b0;
    sample();
  endtask

  task automatic test_reset();
    nRST = 1'b1; dREN_in = 1'b1; dWEN_in = 1'b0; ll_in = 1'b0; sc_in = 1'b0;
    dhit = 1'b0; addr_in = 32'h0000_0040; store_in = 32'h0; dmemload = 32'h0;
    #1 nRST = 1'b0;
    #2;
    checks++;
    if ({dmemREN, dmemWEN, mem_stall, mem_done, timeout_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {dmemREN, dmemWEN, mem_stall, mem_done, timeout_err});
    end
    checks++;
    if (load_data !== 32'h0 || dmemaddr !== 32'h0 || dmemstore !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got load=%h addr=%h store=%h expected all 0",
               load_data, dmemaddr, dmemstore);
    end
    dREN_in = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_load();
    int r, w, s;
    do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, r, w, s);
    checks++;
    if (s !== 4) begin errors++; $display("[TB] FAIL load_stall_cycles: got %0d expected 4", s); end
    checks++;
    if (r !== 3 || w !== 0) begin
      errors++; $display("[TB] FAIL load_strobes: got ren=%0d wen=%0d expected ren=3 wen=0", r, w);
    end
    checks++;
    if (load_data !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL load_data: got %h expected deadbeef", load_data);
    end
    checks++;
    if (mem_done !== 1'b1 || dmemaddr !== 32'h100) begin
      errors++; $display("[TB] FAIL load_hold: got done=%b addr=%h expected 1/00000100", mem_done, dmemaddr);
    end
    finish_access();
    checks++;
    if (mem_done !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("[TB] FAIL load_idle: got done=%b stall=%b expected 0/0", mem_done, mem_stall);
    end
  endtask

  task automatic test_store();
    int r, w, s;
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h1234_5678, 32'hCAFE_F00D, 1, r, w, s);
    checks++;
    if (w !== 2 || r !== 0) begin
      errors++; $display("[TB] FAIL store_strobes: got wen=%0d ren=%0d expected wen=2 ren=0", w, r);
    end
    checks++;
    if (dmemstore !== 32'h1234_5678 || dmemaddr !== 32'h200) begin
      errors++; $display("[TB] FAIL store_bus: got data=%h addr=%h expected 12345678/00000200", dmemstore, dmemaddr);
    end
    checks++;
    if (load_data !== 32'hDEAD_BEEF || mem_done !== 1'b1) begin
      errors++; $display("[TB] FAIL store_load_data: got %h done=%b expected deadbeef/1", load_data, mem_done);
    end
    finish_access();
  endtask

  task automatic test_both_strobes();
    int r, w, s;
    do_access(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'hA5A5_A5A5, 32'h1111_1111, 0, r, w, s);
    checks++;
    if (w !== 1 || r !== 0) begin
      errors++; $display("[TB] FAIL both_strobes: got wen=%0d ren=%0d expected wen=1 ren=0", w, r);
    end
    checks++;
    if (load_data !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL both_load_data: got %h expected deadbeef", load_data);
    end
    finish_access();
  endtask

  task automatic test_dhit_idle();
    tick();
    dhit = 1'b1; dmemload = 32'hFFFF_0000;
    sample();
    checks++;
    if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
      errors++; $display("[TB] FAIL idle_dhit_outputs: got %b expected 000", {dmemREN, dmemWEN, mem_stall});
    end
    tick();
    dhit = 1'b0; dmemload = '0;
    sample();
    checks++;
    if (mem_done !== 1'b0 || load_data !== 32'hDEAD_BEEF) begin
      errors++; $display("[TB] FAIL idle_dhit_ignored: got done=%b load=%h expected 0/deadbeef", mem_done, load_data);
    end
  endtask

`ifdef LLSC_EN
  task automatic test_llsc();
    int r, w, s;
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0000_0077, 0, r, w, s);
    checks++;
    if (load_data !== 32'h77) begin errors++; $display("[TB] FAIL ll_load: got %h expected 00000077", load_data); end
    finish_access();
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h99, 32'h0, 0, r, w, s);
    checks++;
    if (w !== 1 || load_data !== 32'h1) begin
      errors++; $display("[TB] FAIL sc_pass: got wen=%0d load=%h expected 1/00000001", w, load_data);
    end
    finish_access();
    tick();
    dWEN_in = 1'b1; sc_in = 1'b1; addr_in = 32'h300; store_in = 32'h99;
    sample();
    checks++;
    if ({mem_stall, dmemREN, dmemWEN} !== 3'b100) begin
      errors++; $display("[TB] FAIL sc_fail_accept: got %b expected 100", {mem_stall, dmemREN, dmemWEN});
    end
    tick();
    sample();
    checks++;
    if ({dmemREN, dmemWEN, mem_stall, mem_done} !== 4'b0001 || load_data !== 32'h0) begin
      errors++; $display("[TB] FAIL sc_fail_hold: got flags=%b load=%h expected 0001/00000000",
                         {dmemREN, dmemWEN, mem_stall, mem_done}, load_data);
    end
    finish_access();
  endtask
`else
  task automatic test_sc_plain();
    int r, w, s;
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 32'h0000_0077, 0, r, w, s);
    checks++;
    if (load_data !== 32'h77 || r !== 1) begin
      errors++; $display("[TB] FAIL ll_plain_load: got %h ren=%0d expected 00000077/1", load_data, r);
    end
    finish_access();
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h99, 32'h0, 0, r, w, s);
    checks++;
    if (w !== 1 || load_data !== 32'h1) begin
      errors++; $display("[TB] FAIL sc_plain: got wen=%0d load=%h expected 1/00000001", w, load_data);
    end
    finish_access();
  endtask
`endif

  task automatic test_timeout();
    tick();
    dREN_in = 1'b1; addr_in = 32'h500;
    sample();
    tick();
    sample();
    checks++;
    if (timeout_err !== 1'b0 || dmemREN !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_start: got err=%b ren=%b expected 0/1", timeout_err, dmemREN);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 10) begin
        dhit = 1'b1; dmemload = 32'h0BAD_F00D;
      end
      sample();
      checks++;
      if (timeout_err !== (k >= 4) || mem_stall !== 1'b1) begin
        errors++; $display("[TB] FAIL timeout_wait%0d: got err=%b stall=%b expected %b/1",
                           k, timeout_err, mem_stall, (k >= 4));
      end
    end
    tick();
    dhit = 1'b0; dmemload = '0;
    sample();
    checks++;
    if (mem_done !== 1'b1 || load_data !== 32'h0BAD_F00D || timeout_err !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_complete: got done=%b load=%h err=%b expected 1/0badf00d/1",
                         mem_done, load_data, timeout_err);
    end
    finish_access();
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_sticky: got %b expected 1", timeout_err); end
  endtask

  task automatic test_reset_mid_access();
    tick();
    dREN_in = 1'b1; addr_in = 32'h700;
    sample();
    tick();
    sample();
    checks++;
    if (dmemREN !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre: got ren=%b expected 1", dmemREN); end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({dmemREN, dmemWEN, mem_stall, mem_done, timeout_err} !== 5'b0 || load_data !== 32'h0 || dmemaddr !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_mid_async: got flags=%b load=%h addr=%h expected 00000/0/0",
                         {dmemREN, dmemWEN, mem_stall, mem_done, timeout_err}, load_data, dmemaddr);
    end
    dREN_in = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      sample();
      checks++;
      if ({dmemREN, dmemWEN, mem_stall, mem_done} !== 4'b0) begin
        errors++; $display("[TB] FAIL rst_no_replay%0d: got %b expected 0000", k, {dmemREN, dmemWEN, mem_stall, mem_done});
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_both_strobes();
    test_dhit_idle();
`ifdef LLSC_EN
    test_llsc();
`else
    test_sc_plain();
`endif
    test_timeout();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
